upd_phy_to_llr_unpacker: RTL and testbench

Parametrised successor to the slow PHY-to-LLR path. The block pulls packed IQ words and packed noise words from two first-word-fall-through FIFOs. It emits two REs plus the matching noise sample per output beat to the LLR stage, under valid/ready backpressure. It adds what the earlier block lacked: configurable sample, packing and rate widths, frame length with last/done signalling, correct empty-gated FIFO pops, and a synchronous abort.

---
 rtl/upd_phy_to_llr_unpacker.sv | 170 +++++++++++++++++
 tb/tb_upd_phy_to_llr_unpacker.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/upd_phy_to_llr_unpacker.sv
// rtl/upd_phy_to_llr_unpacker.sv - unpacks FWFT IQ/noise FIFO words into RE-pair beats for the LLR stage
//
// Pulls packed IQ words (RE_PER_WORD complex REs) and packed noise words
// (NOISE_PER_WORD samples) from two first-word-fall-through FIFOs and emits
// one RE pair plus its noise sample per beat under valid/ready handshaking.
//
// Ports:
//   i_core_clk, i_rx_rstn          clock, asynchronous active-low reset
//   i_start, i_abort               frame start (IDLE only), synchronous abort
//   i_re_total                     REs in frame (bit0 ignored)
//   i_user_iq_noise_rate           REs per noise sample (bit0 ignored, min 2)
//   i_iq_fifo_*, o_iq_fifo_rd_en   IQ FIFO (RE k at [2kS+:2S], I low, Q high)
//   i_noise_fifo_*, o_noise_fifo_rd_en  noise FIFO (sample j at [jN+:N])
//   i_ready, o_data_strobe         output handshake
//   o_re0/1_data_i/q, o_noise_data RE pair and matching noise sample
//   o_last, o_busy, o_done         frame end, activity, completion pulse

module upd_phy_to_llr_unpacker #(
  parameter int SAMPLE_W       = 16,
  parameter int RE_PER_WORD    = 4,
  parameter int NOISE_W        = 16,
  parameter int NOISE_PER_WORD = 8,
  parameter int CNT_W          = 16
) (
  input  logic                                 i_core_clk,
  input  logic                                 i_rx_rstn,
  input  logic                                 i_start,
  input  logic                                 i_abort,
  input  logic [CNT_W-1:0]                     i_re_total,
  input  logic [CNT_W-1:0]                     i_user_iq_noise_rate,
  input  logic                                 i_iq_fifo_empty,
  input  logic [2*SAMPLE_W*RE_PER_WORD-1:0]    i_iq_fifo_data,
  output logic                                 o_iq_fifo_rd_en,
  input  logic                                 i_noise_fifo_empty,
  input  logic [NOISE_W*NOISE_PER_WORD-1:0]    i_noise_fifo_data,
  output logic                                 o_noise_fifo_rd_en,
  input  logic                                 i_ready,
  output logic                                 o_data_strobe,
  output logic [SAMPLE_W-1:0]                  o_re0_data_i,
  output logic [SAMPLE_W-1:0]                  o_re0_data_q,
  output logic [SAMPLE_W-1:0]                  o_re1_data_i,
  output logic [SAMPLE_W-1:0]                  o_re1_data_q,
  output logic [NOISE_W-1:0]                   o_noise_data,
  output logic                                 o_last,
  output logic                                 o_busy,
  output logic                                 o_done
);

  localparam int BEATS_PER_WORD = RE_PER_WORD / 2;
  localparam int BI_W = (BEATS_PER_WORD > 1) ? $clog2(BEATS_PER_WORD) : 1;
  localparam int NI_W = (NOISE_PER_WORD > 1) ? $clog2(NOISE_PER_WORD) : 1;
  localparam logic [BI_W-1:0] BI_LAST = BI_W'(BEATS_PER_WORD - 1);
  localparam logic [NI_W-1:0] NI_LAST = NI_W'(NOISE_PER_WORD - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] total_q, rate_q, re_cnt_q, re_in_noise_q;
  logic [BI_W-1:0]  beat_idx_q;
  logic [NI_W-1:0]  noise_idx_q;

  logic [CNT_W-1:0] total_m, rate_m, rate_in;
  logic [CNT_W-1:0] re_in_noise_d;
  logic [BI_W-1:0]  beat_idx_d;
  logic [NI_W-1:0]  noise_idx_d;
  logic             beat, last_beat, noise_wrap;
  logic [4*SAMPLE_W-1:0] iq_pair;
  logic [NOISE_W-1:0]    noise_sel;

  assign total_m = i_re_total & ~CNT_W'(1);
  assign rate_m  = i_user_iq_noise_rate & ~CNT_W'(1);
  assign rate_in = (rate_m < CNT_W'(2)) ? CNT_W'(2) : rate_m;

  assign beat = (state_q == S_RUN) && !i_abort && !i_iq_fifo_empty &&
                !i_noise_fifo_empty && (!o_data_strobe || i_ready);
  assign last_beat = (re_cnt_q + CNT_W'(2)) == total_q;

  // One extra bit so a rate near the CNT_W ceiling cannot wrap the compare.
  assign noise_wrap = ({1'b0, re_in_noise_q} + (CNT_W+1)'(2)) >= {1'b0, rate_q};

  // Last beat pops both FIFOs so leftovers of a partial word never leak into the next frame.
  assign o_iq_fifo_rd_en    = beat && ((beat_idx_q == BI_LAST) || last_beat);
  assign o_noise_fifo_rd_en = beat && ((noise_wrap && (noise_idx_q == NI_LAST)) || last_beat);

  assign beat_idx_d    = (beat_idx_q == BI_LAST) ? '0 : beat_idx_q + BI_W'(1);
  assign re_in_noise_d = noise_wrap ? '0 : re_in_noise_q + CNT_W'(2);
  assign noise_idx_d   = !noise_wrap ? noise_idx_q :
                         (noise_idx_q == NI_LAST) ? '0 : noise_idx_q + NI_W'(1);
  assign o_busy        = (state_q != S_IDLE);

  always_comb begin
    iq_pair   = '0;
    noise_sel = '0;
    for (int b = 0; b < BEATS_PER_WORD; b++) begin
      if (beat_idx_q == BI_W'(b)) iq_pair = i_iq_fifo_data[b*4*SAMPLE_W +: 4*SAMPLE_W];
    end
    for (int j = 0; j < NOISE_PER_WORD; j++) begin
      if (noise_idx_q == NI_W'(j)) noise_sel = i_noise_fifo_data[j*NOISE_W +: NOISE_W];
    end
  end

  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      state_q       <= S_IDLE;
      total_q       <= '0;
      rate_q        <= '0;
      re_cnt_q      <= '0;
      re_in_noise_q <= '0;
      beat_idx_q    <= '0;
      noise_idx_q   <= '0;
      o_data_strobe <= 1'b0;
      o_re0_data_i  <= '0;
      o_re0_data_q  <= '0;
      o_re1_data_i  <= '0;
      o_re1_data_q  <= '0;
      o_noise_data  <= '0;
      o_last        <= 1'b0;
      o_done        <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (i_abort) begin
        state_q       <= S_IDLE;
        o_data_strobe <= 1'b0;
        o_last        <= 1'b0;
        re_cnt_q      <= '0;
        re_in_noise_q <= '0;
        beat_idx_q    <= '0;
        noise_idx_q   <= '0;
      end else begin
        if (beat) begin
          o_data_strobe <= 1'b1;
          o_re0_data_i  <= iq_pair[0*SAMPLE_W +: SAMPLE_W];
          o_re0_data_q  <= iq_pair[1*SAMPLE_W +: SAMPLE_W];
          o_re1_data_i  <= iq_pair[2*SAMPLE_W +: SAMPLE_W];
          o_re1_data_q  <= iq_pair[3*SAMPLE_W +: SAMPLE_W];
          o_noise_data  <= noise_sel;
          o_last        <= last_beat;
          re_cnt_q      <= re_cnt_q + CNT_W'(2);
          beat_idx_q    <= beat_idx_d;
          re_in_noise_q <= re_in_noise_d;
          noise_idx_q   <= noise_idx_d;
        end else if (o_data_strobe && i_ready) begin
          o_data_strobe <= 1'b0;
        end

        case (state_q)
          S_IDLE: begin
            if (i_start) begin
              total_q       <= total_m;
              rate_q        <= rate_in;
              re_cnt_q      <= '0;
              re_in_noise_q <= '0;
              beat_idx_q    <= '0;
              noise_idx_q   <= '0;
              state_q       <= (total_m == '0) ? S_DONE : S_RUN;
            end
          end
          S_RUN:   if (beat && last_beat) state_q <= S_DRAIN;
          S_DRAIN: if (o_data_strobe && i_ready) state_q <= S_DONE;
          S_DONE: begin
            state_q <= S_IDLE;
            o_done  <= 1'b1;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_upd_phy_to_llr_unpacker.sv
// tb/tb_upd_phy_to_llr_unpacker.sv - randomized scoreboard bench for upd_phy_to_llr_unpacker
module tb_upd_phy_to_llr_unpacker;
  localparam int S = 16, RPW = 4, N = 16, NPW = 8, CW = 16;
  localparam int IQW = 2*S*RPW, NZW = N*NPW, HALF = RPW/2, DEPTH = 512;
  localparam int EXPW = 4*S + N + 1;

  logic clk = 1'b0, rst_n = 1'b0;
  logic i_start = 1'b0, i_abort = 1'b0, i_ready = 1'b1;
  logic [CW-1:0] i_re_total = '0, i_rate = '0;
  logic iq_gap = 1'b0, nz_gap = 1'b0;
  logic [IQW-1:0] i_iq_fifo_data;
  logic [NZW-1:0] i_noise_fifo_data;
  logic o_iq_fifo_rd_en, o_noise_fifo_rd_en, o_data_strobe, o_last, o_busy, o_done;
  logic [S-1:0] o_re0_data_i, o_re0_data_q, o_re1_data_i, o_re1_data_q;
  logic [N-1:0] o_noise_data;

  logic [IQW-1:0] iq_mem [DEPTH];
  logic [NZW-1:0] nz_mem [DEPTH];
  int iq_ptr = 0, nz_ptr = 0, miq = 0, mnz = 0;
  logic iq_pop_s = 1'b0, nz_pop_s = 1'b0;

  assign i_iq_fifo_data    = iq_mem[iq_ptr % DEPTH];
  assign i_noise_fifo_data = nz_mem[nz_ptr % DEPTH];

  always #5 clk = ~clk;

  upd_phy_to_llr_unpacker #(.SAMPLE_W(S), .RE_PER_WORD(RPW), .NOISE_W(N),
                            .NOISE_PER_WORD(NPW), .CNT_W(CW)) dut (
    .i_core_clk(clk), .i_rx_rstn(rst_n), .i_start(i_start), .i_abort(i_abort),
    .i_re_total(i_re_total), .i_user_iq_noise_rate(i_rate),
    .i_iq_fifo_empty(iq_gap), .i_iq_fifo_data(i_iq_fifo_data), .o_iq_fifo_rd_en(o_iq_fifo_rd_en),
    .i_noise_fifo_empty(nz_gap), .i_noise_fifo_data(i_noise_fifo_data),
    .o_noise_fifo_rd_en(o_noise_fifo_rd_en), .i_ready(i_ready), .o_data_strobe(o_data_strobe),
    .o_re0_data_i(o_re0_data_i), .o_re0_data_q(o_re0_data_q), .o_re1_data_i(o_re1_data_i),
    .o_re1_data_q(o_re1_data_q), .o_noise_data(o_noise_data), .o_last(o_last),
    .o_busy(o_busy), .o_done(o_done));

  wire [EXPW-1:0] act = {o_re0_data_i, o_re0_data_q, o_re1_data_i, o_re1_data_q, o_noise_data, o_last};

  int n_vec = 0, n_err = 0, cyc = 0, done_cnt = 0;
  int exp_done_cyc = -1, start_cyc = 0, done_seen_cyc = 0;
  logic [EXPW-1:0] exp_q[$];
  logic held = 1'b0;
  logic [EXPW-1:0] held_val;

  task automatic fail(string nm, logic [127:0] got, logic [127:0] want);
    n_err++;
    $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, want, cyc);
  endtask

  // FIFO model: pops observed mid-cycle take effect just after the next edge.
  always @(posedge clk) begin
    #1;
    if (iq_pop_s) iq_ptr++;
    if (nz_pop_s) nz_ptr++;
  end

  // Monitor / scoreboard checker.
  always @(negedge clk) begin
    logic [EXPW-1:0] e;
    if (!rst_n) begin
      held = 1'b0; iq_pop_s = 1'b0; nz_pop_s = 1'b0;
    end else begin
      iq_pop_s = o_iq_fifo_rd_en;
      nz_pop_s = o_noise_fifo_rd_en;
      if (o_iq_fifo_rd_en) begin
        n_vec++;
        if (iq_gap) fail("iq_rd_en_while_empty", 128'(iq_gap), 128'(0));
      end
      if (o_noise_fifo_rd_en) begin
        n_vec++;
        if (nz_gap) fail("noise_rd_en_while_empty", 128'(nz_gap), 128'(0));
      end
      if (held) begin
        n_vec++;
        if (!o_data_strobe || act !== held_val) fail("held_output_stable", 128'({o_data_strobe, act}), 128'({1'b1, held_val}));
      end
      held = o_data_strobe && !i_ready;
      held_val = act;
      if (o_data_strobe && i_ready) begin
        n_vec++;
        if (exp_q.size() == 0) fail("unexpected_beat", 128'(act), 128'(0));
        else begin
          e = exp_q.pop_front();
          if (act !== e) fail("beat", 128'(act), 128'(e));
          if (e[0]) exp_done_cyc = cyc + 2;
        end
      end
      if (i_start && !o_busy && !i_abort) begin
        start_cyc = cyc;
        if ((i_re_total >> 1) == 0) exp_done_cyc = cyc + 2;
      end
      if (o_done) begin
        n_vec++;
        done_cnt++;
        done_seen_cyc = cyc;
        if (cyc != exp_done_cyc) fail("done_timing", 128'(cyc), 128'(exp_done_cyc));
        exp_done_cyc = -1;
      end
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int eff_rate(int r);
    int m = r & ~1;
    return (m < 2) ? 2 : m;
  endfunction

  // Reference: beat k of a frame takes REs 2k,2k+1 of the frame's RE stream and
  // noise sample floor(2k/rate) of the frame's noise stream; every frame starts on fresh words.
  task automatic expect_beats(int nb_frame, int rate_e, int nb_run);
    logic [IQW-1:0] w;
    logic [NZW-1:0] z;
    int s;
    for (int k = 0; k < nb_run; k++) begin
      s = k / (rate_e/2);
      w = iq_mem[(miq + k/HALF) % DEPTH] >> ((2*(k%HALF))*2*S);
      z = nz_mem[(mnz + s/NPW) % DEPTH] >> ((s%NPW)*N);
      exp_q.push_back({w[S-1:0], w[2*S-1:S], w[3*S-1:2*S], w[4*S-1:3*S], z[N-1:0], (k == nb_frame-1)});
    end
  endtask

  task automatic check_ptrs(string tag);
    n_vec++;
    if (iq_ptr != miq) fail({tag, "_iq_pops"}, 128'(iq_ptr), 128'(miq));
    n_vec++;
    if (nz_ptr != mnz) fail({tag, "_noise_pops"}, 128'(nz_ptr), 128'(mnz));
    n_vec++;
    if (exp_q.size() != 0) fail({tag, "_beats_missing"}, 128'(exp_q.size()), 128'(0));
  endtask

  task automatic run_frame(int total, int rate, int rmode, int gmode);
    int nb, re, d0, i;
    logic [3:0] rpat;
    rpat = 4'b1001;
    nb = total / 2;
    re = eff_rate(rate);
    d0 = done_cnt;
    expect_beats(nb, re, nb);
    miq += (nb + HALF - 1) / HALF;
    mnz += (nb > 0) ? ((nb-1)/(re/2))/NPW + 1 : 0;
    i_re_total = CW'(total);
    i_rate = CW'(rate);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    if (nb == 0) begin
      n_vec++;
      if (o_busy !== 1'b1) fail("zero_frame_busy", 128'(o_busy), 128'(1));
    end
    i = 0;
    while (done_cnt == d0 && i < 2000) begin
      case (rmode)
        0: i_ready = 1'b1;
        1: i_ready = ($urandom_range(0, 3) != 0);
        default: i_ready = rpat[i%4];
      endcase
      case (gmode)
        0: begin iq_gap = 1'b0; nz_gap = 1'b0; end
        1: begin iq_gap = ($urandom_range(0, 4) == 0); nz_gap = ($urandom_range(0, 6) == 0); end
        default: iq_gap = (i >= 2 && i < 7);
      endcase
      tick();
      i++;
    end
    i_ready = 1'b1; iq_gap = 1'b0; nz_gap = 1'b0;
    n_vec++;
    if (done_cnt == d0) fail("frame_done_timeout", 128'(done_cnt), 128'(d0 + 1));
    if (rmode == 0 && gmode == 0) begin
      n_vec++;
      if (done_seen_cyc - start_cyc != ((nb == 0) ? 2 : nb + 3))
        fail("frame_latency", 128'(done_seen_cyc - start_cyc), 128'((nb == 0) ? 2 : nb + 3));
    end
    tick();
    check_ptrs("frame");
  endtask

  initial begin
    int d0;
    for (int i = 0; i < DEPTH; i++) begin
      iq_mem[i] = {$urandom, $urandom, $urandom, $urandom};
      nz_mem[i] = {$urandom, $urandom, $urandom, $urandom};
    end
    repeat (3) tick();
    n_vec++;
    if ({o_data_strobe, o_busy, o_done, o_iq_fifo_rd_en, o_noise_fifo_rd_en, act} !== '0)
      fail("reset_outputs", 128'({o_data_strobe, o_busy, o_done, o_iq_fifo_rd_en, o_noise_fifo_rd_en, act}), 128'(0));
    rst_n = 1'b1;
    tick();

    run_frame(16, 4, 0, 0);
    run_frame(6, 2, 0, 0);
    run_frame(24, 6, 2, 0);
    run_frame(24, 4, 0, 2);
    run_frame(0, 4, 0, 0);
    run_frame(9, 1, 0, 0);

    // Abort after three beats, then restart from a clean frame.
    d0 = done_cnt;
    expect_beats(8, 4, 3);
    miq += 3 / HALF;
    mnz += 3 / (2 * NPW);
    i_re_total = CW'(16); i_rate = CW'(4); i_ready = 1'b1;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (3) tick();
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    n_vec++;
    if ({o_data_strobe, o_busy} !== 2'b00) fail("abort_idle", 128'({o_data_strobe, o_busy}), 128'(0));
    repeat (4) tick();
    n_vec++;
    if (done_cnt != d0) fail("abort_no_done", 128'(done_cnt), 128'(d0));
    check_ptrs("abort");
    run_frame(8, 4, 0, 0);

    for (int f = 0; f < 8; f++)
      run_frame(int'($urandom_range(0, 40)), int'($urandom_range(0, 12)), 1, 1);

    // Asynchronous reset in the middle of a frame: only the first beat is accepted.
    expect_beats(20, 6, 1);
    i_re_total = CW'(40); i_rate = CW'(6);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({o_data_strobe, o_busy, o_done, o_iq_fifo_rd_en, o_noise_fifo_rd_en, act} !== '0)
      fail("async_reset_outputs", 128'({o_data_strobe, o_busy, o_done, o_iq_fifo_rd_en, o_noise_fifo_rd_en, act}), 128'(0));
    tick();
    iq_ptr = 300; nz_ptr = 300; miq = 300; mnz = 300;
    exp_done_cyc = -1;
    check_ptrs("reset");
    rst_n = 1'b1;
    tick();
    run_frame(10, 20, 1, 1);
    run_frame(16, 4, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
